// File: rtl/overworld_pokemon_sprite.sv
// overworld_pokemon_sprite: frame-latched sprite hit test, 3-stage sprite ROM lookup with per-species transparency and frame-count animation
module overworld_pokemon_sprite #(
  parameter int SPRITE_DIM = 32,
  parameter int ANIM_DIV = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       pixel_req,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] sprite_x,
  input  logic [9:0] sprite_y,
  input  logic [2:0] pokemon_sel,
  input  logic       enable,
  output logic [13:0] rom_addr,
  input  logic [2:0] rom_data,
  output logic [2:0] index,
  output logic [2:0] pal_sel,
  output logic       pixel_valid,
  output logic       anim_frame
);
  localparam int CW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  logic [9:0] sx, sy;
  logic [2:0] ssel, sel1, sel2;
  logic sen, hit, hit1, hit2, key, vis;
  logic [CW-1:0] cnt;
  logic [10:0] dx, dy;
  logic [13:0] addr;
  always_comb begin
    dx = {1'b0, DrawX} - {1'b0, sx};
    dy = {1'b0, DrawY} - {1'b0, sy};
    hit = pixel_req & sen & (ssel <= 3'd4) & (DrawX >= sx) & (dx < 11'(SPRITE_DIM))
        & (DrawY >= sy) & (dy < 11'(SPRITE_DIM));
    addr = {ssel, anim_frame, 10'd0} + 14'(dy) * 14'(SPRITE_DIM) + 14'(dx);
    key = (sel2 == 3'd0 || sel2 == 3'd3) ? rom_data == 3'd1 :
          sel2 == 3'd4 ? (rom_data == 3'd0 || rom_data == 3'd5) : rom_data == 3'd0;
    vis = hit2 & ~key;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sx <= '0;
      sy <= '0;
      ssel <= '0;
      sen <= 1'b0;
      cnt <= '0;
      anim_frame <= 1'b0;
      rom_addr <= '0;
      hit1 <= 1'b0;
      hit2 <= 1'b0;
      sel1 <= '0;
      sel2 <= '0;
      index <= '0;
      pal_sel <= '0;
      pixel_valid <= 1'b0;
    end else begin
      if (frame_start) begin
        sx <= sprite_x;
        sy <= sprite_y;
        ssel <= pokemon_sel;
        sen <= enable;
        if (pokemon_sel != ssel || !enable) begin
          cnt <= '0;
          anim_frame <= 1'b0;
        end else if (cnt == CW'(ANIM_DIV - 1)) begin
          cnt <= '0;
          anim_frame <= ~anim_frame;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      rom_addr <= hit ? addr : '0;
      hit1 <= hit;
      sel1 <= ssel;
      hit2 <= hit1;
      sel2 <= sel1;
      pixel_valid <= vis;
      index <= vis ? rom_data : '0;
      pal_sel <= vis ? sel2 : '0;
    end
  end
endmodule

// File: doc/overworld_pokemon_sprite.md
OVERWORLD_POKEMON_SPRITE -- requirements
Module: overworld_pokemon_sprite

Interface
REQ-001 SHALL have parameter SPRITE_DIM, default 32, sprite width and height in pixels (power of two).
REQ-002 SHALL have parameter ANIM_DIV, default 30, number of frames per animation-frame toggle.
REQ-003 SHALL have port Clk  input  1  single clock.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blank.
REQ-006 SHALL have port pixel_req  input  1  DrawX/DrawY valid this cycle.
REQ-007 SHALL have port DrawX  input  10  current pixel column.
REQ-008 SHALL have port DrawY  input  10  current pixel row.
REQ-009 SHALL have port sprite_x  input  10  requested sprite left edge.
REQ-010 SHALL have port sprite_y  input  10  requested sprite top edge.
REQ-011 SHALL have port pokemon_sel  input  3  0 bulbasaur, 1 charmander, 2 pikachu, 3 poliwrath, 4 squirtle, 5-7 none.
REQ-012 SHALL have port enable  input  1  requested sprite visibility.
REQ-013 SHALL have port rom_addr  output  14  sprite ROM address, registered.
REQ-014 SHALL have port rom_data  input  3  palette index from sync ROM, valid the cycle after rom_addr changes.
REQ-015 SHALL have port index  output  3  palette index to palette stage.
REQ-016 SHALL have port pal_sel  output  3  which palette module output to use.
REQ-017 SHALL have port pixel_valid  output  1  opaque sprite pixel present.
REQ-018 SHALL have port anim_frame  output  1  current animation frame.

Function
REQ-019 SHALL latch sprite_x, sprite_y, pokemon_sel, enable into shadow registers only on cycles with frame_start=1; shadows used for all hit tests.
REQ-020 SHALL, with frame_start and pixel_req in the same cycle, evaluate that pixel with pre-update shadow values.
REQ-021 SHALL compute hit = pixel_req & shadow enable & shadow sel<=4 & sx<=DrawX<=sx+SPRITE_DIM-1 & sy<=DrawY<=sy+SPRITE_DIM-1, in 11-bit arithmetic (no wrap past 1023).
REQ-022 SHALL form rom_addr = sel*2048 + anim_frame*1024 + (DrawY-sy)*SPRITE_DIM + (DrawX-sx) when hit, else 0, registered at end of request cycle t.
REQ-023 SHALL pipeline hit and sel alongside the ROM access; rom_data sampled in cycle t+2.
REQ-024 SHALL register index, pal_sel, pixel_valid at end of cycle t+2, visible in cycle t+3 (latency 3, throughput 1 pixel/cycle).
REQ-025 SHALL treat transparency key per sel: 0->index 1, 1->0, 2->0, 3->1, 4->0 or 5; key match forces pixel_valid=0.
REQ-026 SHALL drive index=0, pal_sel=0, pixel_valid=0 for any non-hit or transparent pixel.
REQ-027 SHALL count frame_start pulses 0..ANIM_DIV-1 while shadow enable=1; on wrap to 0 toggle anim_frame.
REQ-028 SHALL hold counter at 0 and anim_frame at 0 while shadow enable=0.
REQ-029 SHALL clear counter and anim_frame to 0 on any frame_start that changes shadow sel.
REQ-030 SHALL apply an anim_frame change to rom_addr from the cycle after the toggling frame_start.

Reset
REQ-031 SHALL, on Reset=1 at a clock edge, set all shadows, counter, anim_frame, rom_addr, index, pal_sel, pixel_valid and pipeline hit flags to 0.
REQ-032 SHALL discard in-flight pixels when Reset asserts mid-pipeline; pixel_valid=0 from the cycle after the reset edge until a new hit completes.
REQ-033 SHALL ignore pixel_req while no frame_start has occurred since reset (shadow enable=0).

Verification
REQ-034 Bench SHALL cover: frame_start with sel=2, sx=100, sy=50, enable=1; pixel_req DrawX=100, DrawY=50 -> rom_addr=4096 next cycle; rom_data=3 -> index=3, pal_sel=2, pixel_valid=1 three cycles after request.
REQ-035 Bench SHALL cover: same setup, DrawX=131/132, DrawY=81 -> 131 hits (rom_addr=4096+31*32+31=5119), 132 gives pixel_valid=0, rom_addr=0.
REQ-036 Bench SHALL cover: sel=3, rom_data=1 on hit -> pixel_valid=0, index=0; sel=4, rom_data=5 -> pixel_valid=0.
REQ-037 Bench SHALL cover: enable=1, ANIM_DIV=30, 30 frame_start pulses -> anim_frame=1; next hit at local (0,0), sel=0 -> rom_addr=1024; sel changed at next frame_start -> anim_frame=0.
REQ-038 Bench SHALL cover: sx=1000, DrawX=1023 hit and DrawX=5 no hit (no wrap); sel=6 -> never hit.
REQ-039 Bench SHALL cover: Reset asserted one cycle after hit request -> pixel_valid stays 0; shadows cleared, following requests miss until next frame_start.
